// File: rtl/kamus_if_id_queue_if.sv
// Fetch-to-decode queue bundle: fetch push side, decode pop side, flush and occupancy.
interface kamus_if_id_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic            if_valid_i;
    logic [31:0]     if_instr_i;
    logic [31:0]     if_next_pc_i;
    logic            if_ready_o;
    logic            flush_i;
    logic            id_valid_o;
    logic [31:0]     id_instr_o;
    logic [31:0]     id_pc_o;
    logic [31:0]     id_next_pc_o;
    logic            id_ready_i;
    logic [CntW-1:0] count_o;

    // Environment side: drives fetch words, flush and decode ready.
    modport master (
        output if_valid_i, if_instr_i, if_next_pc_i, flush_i, id_ready_i,
        input  if_ready_o, id_valid_o, id_instr_o, id_pc_o, id_next_pc_o, count_o
    );

    // Queue side.
    modport slave (
        input  if_valid_i, if_instr_i, if_next_pc_i, flush_i, id_ready_i,
        output if_ready_o, id_valid_o, id_instr_o, id_pc_o, id_next_pc_o, count_o
    );
endinterface

// File: rtl/kamus_if_id_queue.sv
// Instruction fetch queue between IF and ID: FWFT head, NOP when empty, flush on redirect.
module kamus_if_id_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    kamus_if_id_queue_if.slave   q
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    logic [31:0]     instr_q   [DEPTH];
    logic [31:0]     next_pc_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic ready;
    logic valid;
    logic push_en;
    logic pop_en;

    // Handshake qualifiers; ready depends only on registered count so a pop never frees a slot
    // in the same cycle.
    always_comb begin
        ready   = (count_q < DepthCnt);
        valid   = (count_q != '0);
        push_en = q.if_valid_i && ready;
        pop_en  = valid && q.id_ready_i;
    end

    // Next-state for pointers and occupancy; flush discards any concurrent push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (q.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (push_en && !pop_en) begin
                count_d = count_q + CntW'(1);
            end else if (pop_en && !push_en) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    // Pointer and occupancy state with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; data needs no reset since validity comes from count.
    always_ff @(posedge clk_i) begin
        if (rst_ni && !q.flush_i && push_en) begin
            instr_q[wr_ptr_q]   <= q.if_instr_i;
            next_pc_q[wr_ptr_q] <= q.if_next_pc_i;
        end
    end

    // First-word-fall-through head with empty defaults.
    always_comb begin
        q.if_ready_o   = ready;
        q.id_valid_o   = valid;
        q.count_o      = count_q;
        q.id_instr_o   = NOP_INSTR;
        q.id_pc_o      = '0;
        q.id_next_pc_o = '0;
        if (valid) begin
            q.id_instr_o   = instr_q[rd_ptr_q];
            q.id_next_pc_o = next_pc_q[rd_ptr_q];
            q.id_pc_o      = next_pc_q[rd_ptr_q] - 32'h4;
        end
    end

    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= DepthCnt);
    a_push_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
        push_en |-> ready);
    a_nop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !valid |-> (q.id_instr_o == NOP_INSTR));

endmodule

// File: tb/tb_kamus_if_id_queue.sv
// Self-checking bench for kamus_if_id_queue: directed vector table plus random run vs queue model.
module tb_kamus_if_id_queue;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    kamus_if_id_queue_if #(.DEPTH(DEPTH)) bus ();

    kamus_if_id_queue #(
        .DEPTH     (DEPTH),
        .NOP_INSTR (NOP)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .q      (bus)
    );

    typedef struct {
        logic        rst_n;
        logic        ifv;
        logic [31:0] instr;
        logic [31:0] npc;
        logic        flush;
        logic        idr;
        logic        ev;
        logic [31:0] ei;
        logic [31:0] epc;
        logic [31:0] enpc;
        int          ecnt;
        logic        erdy;
    } vec_t;

    vec_t vecs[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic v, input logic [31:0] ins,
                       input logic [31:0] np, input logic f, input logic rd,
                       input logic ev, input logic [31:0] ei, input logic [31:0] epc,
                       input logic [31:0] enpc, input int ecnt, input logic erdy);
        vec_t t;
        t.rst_n = r; t.ifv = v; t.instr = ins; t.npc = np; t.flush = f; t.idr = rd;
        t.ev = ev; t.ei = ei; t.epc = epc; t.enpc = enpc; t.ecnt = ecnt; t.erdy = erdy;
        vecs.push_back(t);
    endtask

    // Expect empty queue after the edge.
    task automatic add_e(input logic r, input logic v, input logic [31:0] ins,
                         input logic [31:0] np, input logic f, input logic rd);
        add(r, v, ins, np, f, rd, 1'b0, NOP, 32'h0, 32'h0, 0, 1'b1);
    endtask

    task automatic drive(input logic r, input logic v, input logic [31:0] ins,
                         input logic [31:0] np, input logic f, input logic rd);
        rst_n            = r;
        bus.if_valid_i   = v;
        bus.if_instr_i   = ins;
        bus.if_next_pc_i = np;
        bus.flush_i      = f;
        bus.id_ready_i   = rd;
    endtask

    task automatic check_outs(input string tag, input int idx, input logic ev,
                              input logic [31:0] ei, input logic [31:0] epc,
                              input logic [31:0] enpc, input int ecnt, input logic erdy);
        chk({tag, ".id_valid"},   idx, {31'd0, bus.id_valid_o}, {31'd0, ev});
        chk({tag, ".id_instr"},   idx, bus.id_instr_o, ei);
        chk({tag, ".id_pc"},      idx, bus.id_pc_o, epc);
        chk({tag, ".id_next_pc"}, idx, bus.id_next_pc_o, enpc);
        chk({tag, ".count"},      idx, 32'(bus.count_o), 32'(ecnt));
        chk({tag, ".if_ready"},   idx, {31'd0, bus.if_ready_o}, {31'd0, erdy});
    endtask

    // Behavioural model: a plain queue of {instr, next_pc} pairs.
    logic [63:0] model[$];

    initial begin
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Reset and idle.
        add_e(0, 0, 32'h0, 32'h0, 0, 0);
        add_e(1, 0, 32'h0, 32'h0, 0, 0);
        // Single push then pop.
        add(1, 1, 32'h00500093, 32'h4, 0, 0, 1, 32'h00500093, 32'h0, 32'h4, 1, 1);
        add_e(1, 0, 32'h0, 32'h0, 0, 1);
        // Fill to full, then a push refused while popping.
        add(1, 1, 32'hA1, 32'h4,  0, 0, 1, 32'hA1, 32'h0, 32'h4, 1, 1);
        add(1, 1, 32'hA2, 32'h8,  0, 0, 1, 32'hA1, 32'h0, 32'h4, 2, 1);
        add(1, 1, 32'hA3, 32'hC,  0, 0, 1, 32'hA1, 32'h0, 32'h4, 3, 1);
        add(1, 1, 32'hA4, 32'h10, 0, 0, 1, 32'hA1, 32'h0, 32'h4, 4, 0);
        add(1, 1, 32'hA5, 32'h14, 0, 1, 1, 32'hA2, 32'h4, 32'h8, 3, 1);
        add(1, 0, 32'h0,  32'h0,  0, 1, 1, 32'hA3, 32'h8, 32'hC, 2, 1);
        add(1, 0, 32'h0,  32'h0,  0, 1, 1, 32'hA4, 32'hC, 32'h10, 1, 1);
        add_e(1, 0, 32'h0, 32'h0, 0, 1);
        // Continuous push/pop of 10 words; pointers wrap.
        for (int k = 0; k < 10; k++) begin
            add(1, 1, 32'h1000_0000 + 32'(k), 32'(4 * (k + 1)), 0, 1,
                1, 32'h1000_0000 + 32'(k), 32'(4 * k), 32'(4 * (k + 1)), 1, 1);
        end
        add_e(1, 0, 32'h0, 32'h0, 0, 1);
        // Flush with 3 held entries and a simultaneous push.
        add(1, 1, 32'hF0, 32'h200, 0, 0, 1, 32'hF0, 32'h1FC, 32'h200, 1, 1);
        add(1, 1, 32'hF1, 32'h204, 0, 0, 1, 32'hF0, 32'h1FC, 32'h200, 2, 1);
        add(1, 1, 32'hF2, 32'h208, 0, 0, 1, 32'hF0, 32'h1FC, 32'h200, 3, 1);
        add_e(1, 1, 32'hF3, 32'h20C, 1, 1);
        add(1, 1, 32'hF4, 32'h104, 0, 0, 1, 32'hF4, 32'h100, 32'h104, 1, 1);
        // Back-to-back flushes keep it empty.
        add_e(1, 1, 32'hF5, 32'h300, 1, 0);
        add_e(1, 1, 32'hF6, 32'h304, 1, 1);
        add_e(1, 0, 32'h0, 32'h0, 0, 1);
        // next_pc 0 wraps pc; then reset mid-stream with push and pop.
        add(1, 1, 32'hB0, 32'h0, 0, 0, 1, 32'hB0, 32'hFFFF_FFFC, 32'h0, 1, 1);
        add(1, 1, 32'hB1, 32'h8, 0, 0, 1, 32'hB0, 32'hFFFF_FFFC, 32'h0, 2, 1);
        add_e(0, 1, 32'hB2, 32'hC, 0, 1);
        add_e(1, 0, 32'h0, 32'h0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].ifv, vecs[i].instr, vecs[i].npc, vecs[i].flush,
                  vecs[i].idr);
            @(posedge clk);
            #1;
            check_outs("vec", i, vecs[i].ev, vecs[i].ei, vecs[i].epc, vecs[i].enpc,
                       vecs[i].ecnt, vecs[i].erdy);
        end

        // Random run against the queue model (DUT is empty here).
        model.delete();
        for (int c = 0; c < 3000; c++) begin
            logic r, v, f, rd;
            logic [31:0] ins, np;
            logic can_push, can_pop;
            r   = ($urandom_range(0, 99) != 0);
            f   = ($urandom_range(0, 15) == 0);
            v   = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 2) != 0);
            ins = $urandom;
            np  = (c % 50 == 7) ? 32'h0 : ($urandom & 32'hFFFF_FFFC);
            drive(r, v, ins, np, f, rd);
            can_push = v && (model.size() < DEPTH);
            can_pop  = rd && (model.size() != 0);
            if (!r || f) begin
                model.delete();
            end else begin
                if (can_pop) void'(model.pop_front());
                if (can_push) model.push_back({ins, np});
            end
            @(posedge clk);
            #1;
            if (model.size() == 0) begin
                check_outs("rnd", c, 1'b0, NOP, 32'h0, 32'h0, 0, 1'b1);
            end else begin
                check_outs("rnd", c, 1'b1, model[0][63:32], model[0][31:0] - 32'h4,
                           model[0][31:0], model.size(), model.size() < DEPTH);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/kamus_if_id_queue.md
Name: kamus_if_id_queue

Overview:
- Instruction fetch queue between the fetch stage and the decode stage.
- Buffers fetched instruction words with their PC so fetch and decode are decoupled by a valid/ready handshake.
- Flushes on redirect (taken branch / jump).
- Presents a first-word-fall-through head to decode and a canonical NOP when empty.

Parameters:
- DEPTH, 4, number of entries; power of two, DEPTH >= 2.
- NOP_INSTR, 32'h0000_0013, word driven on id_instr_o when no valid entry (addi x0,x0,0).

Ports:
- clk_i  input  1  clock, all state updates on rising edge.
- rst_ni  input  1  synchronous active-low reset.
- if_valid_i  input  1  fetch presents a valid instruction this cycle.
- if_instr_i  input  32  instruction word from fetch.
- if_next_pc_i  input  32  PC+4 of the presented instruction.
- if_ready_o  output  1  queue accepts a word this cycle.
- flush_i  input  1  redirect; discard all contents.
- id_valid_o  output  1  head entry valid.
- id_instr_o  output  32  head instruction, or NOP_INSTR when empty.
- id_pc_o  output  32  head instruction PC (stored next_pc − 4), 0 when empty.
- id_next_pc_o  output  32  head next_pc, 0 when empty.
- id_ready_i  input  1  decode consumes head this cycle.
- count_o  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage:
  - DEPTH entries of {instr[31:0], next_pc[31:0]}.
  - Write pointer and read pointer are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
  - Occupancy counter is $clog2(DEPTH)+1 bits.
- Reset (rst_ni low at clock edge): pointers=0, count=0. Outputs then read id_valid_o=0, id_instr_o=NOP_INSTR, id_pc_o=0, id_next_pc_o=0, count_o=0, if_ready_o=1. Reset has priority over flush and all handshakes, including mid-stream.
- Push:
  - Occurs when if_valid_i && if_ready_o.
  - Entry written at the write pointer; pointer +1.
- if_ready_o:
  - Equals (count < DEPTH), computed from registered count only.
  - A full queue refuses a push even when a pop occurs in the same cycle; there is no combinational path from id_ready_i.
- Pop:
  - Occurs when id_valid_o && id_ready_i; read pointer +1.
  - id_ready_i while empty has no effect.
- Head output is first-word-fall-through:
  - id_valid_o = (count != 0).
  - id_instr_o, id_pc_o, id_next_pc_o are driven combinationally from the read-pointer entry, or from the empty defaults.
- Latency: a word pushed at edge N is visible on the id_* outputs after edge N (next cycle); there is no same-cycle bypass.
- Count update:
  - push only: +1. pop only: −1. Both or neither: unchanged.
- id_pc_o arithmetic: next_pc − 32'h4, modulo 2^32 (next_pc 0 gives 32'hFFFF_FFFC).
- Flush:
  - If flush_i=1 at an edge: pointers=0, count=0.
  - A push or pop attempted in the same cycle is discarded; the pushed word is not stored.
  - if_ready_o and id_* outputs in the flush cycle still reflect the pre-flush state.
  - The queue is empty in the following cycle.
  - Consecutive flush cycles keep the queue empty.
- Wrap-around: pointer rollover from DEPTH−1 to 0 preserves FIFO order. Order is always strictly FIFO.
- No overflow or underflow is possible by construction. Assertions are required for: count <= DEPTH; no push when !if_ready_o; id_instr_o == NOP_INSTR whenever !id_valid_o.

Test Plan:
- Reset then idle -> id_valid_o=0, id_instr_o=32'h0000_0013, id_pc_o=0, count_o=0, if_ready_o=1.
- Push {instr 32'h00500093, next_pc 32'h4} with id_ready_i=0 -> next cycle id_valid_o=1, id_instr_o=32'h00500093, id_pc_o=0, id_next_pc_o=4, count_o=1.
- Push 4 words (next_pc 4,8,C,10) with id_ready_i=0 -> count_o=4, if_ready_o=0. Fifth push with id_ready_i=1 same cycle -> not stored, count_o=3 next cycle, head id_pc_o=4.
- Continuous push/pop for 10 words (wraps pointers twice) -> ID receives PCs 0,4,...,0x24 in order; count_o constant 1 after first cycle.
- Queue holding 3 entries, flush_i=1 with simultaneous push -> next cycle count_o=0, id_valid_o=0, id_instr_o=NOP; a push on the following cycle of next_pc 32'h104 appears as id_pc_o=32'h100.
- Queue holding 2 entries, rst_ni=0 for one cycle together with push and pop -> next cycle count_o=0, id_valid_o=0, if_ready_o=1.
